execute_mem_reg: RTL
====================

// Module: execute_mem_reg
// PURPOSE
//  Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline.
//  Consumes the ID/EX register outputs and applies forwarding to both operands.
//  Computes the ALU result and the destination register.
//  Registers the result, store data and control bits into the MEM stage, with stall (hold) and flush.
// PARAMETERS
//  WIDTH    32  datapath width
//  REGBITS  5   register-file address width
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        async active-low reset
//  stallM       in   1        hold EX/MEM contents this cycle
//  flushM       in   1        insert bubble into EX/MEM
//  RegWriteE    in   1        ID/EX: register write enable
//  MemtoRegE    in   1        ID/EX: writeback selects memory data
//  MemWriteE    in   1        ID/EX: store
//  ALUSrcE      in   1        ID/EX: 1 = SrcB is SignImmE
//  RegDstE      in   1        ID/EX: 1 = dest is RdE, 0 = RtE
//  ALUControlE  in   3        ID/EX: ALU op
//  RD1E,RD2E    in   WIDTH    ID/EX: register operands
//  SignImmE     in   WIDTH    ID/EX: sign-extended immediate
//  RtE,RdE      in   REGBITS  ID/EX: register numbers
//  ForwardAE    in   2        SrcA select from hazard unit
//  ForwardBE    in   2        SrcB-pre select from hazard unit
//  ResultW      in   WIDTH    WB-stage result for forwarding
//  RegWriteM,MemtoRegM,MemWriteM  out 1  registered control
//  ALUOutM      out  WIDTH    registered ALU result; also fed back for forwarding
//  WriteDataM   out  WIDTH    registered forwarded RD2 (store data)
//  WriteRegM    out  REGBITS  registered destination register
//  OverflowM    out  1        registered signed overflow of add/sub
//  ValidM       out  1        1 = EX/MEM holds a real instruction
// BEHAVIOUR
//  Reset (rst=0, async): every output and internal register goes to 0. Reset mid-stall also clears.
//  Forward mux (ForwardAE/BE): 00 = RD1E/RD2E, 01 = ResultW, 10 = ALUOutM, 11 = same as 00.
//  SrcA = fwdA. WriteDataE = fwdB. SrcB = ALUSrcE ? SignImmE : fwdB.
//  ALUControl encodings:
//    010 add, 110 sub, 000 and, 001 or, 011 xor, 100 nor
//    111 slt (signed; result 1/0 zero-extended)
//    101 sltu (unsigned)
//  Arithmetic wraps modulo 2^WIDTH.
//  Overflow: set only for add/sub, when the operand and result signs indicate signed overflow.
//  Overflow is reported only; it never blocks a write.
//  WriteRegE = RegDstE ? RdE : RtE.
//  ValidE = RegWriteE | MemWriteE | (ALUControlE != 000) | (RtE != 0).
//    A zero ID/EX bubble therefore gives ValidE = 0.
//  Clock edge priority: flushM > stallM > load.
//    flushM: all M registers cleared to 0 (bubble).
//    stallM: all M registers hold.
//    else: all M registers load E-stage values. Latency is 1 cycle E -> M.
//  flushM and stallM together: flush wins. A bubble then holds if stallM persists.
//  Forwarding reads the current ALUOutM (pre-edge value); no combinational loop via ALUOutM.
//  While stallM=1, ALUOutM is stable, so the E stage stays deterministic across the stall.
//  Writes to register 0 pass through unchanged; the register file ignores them.
// STRUCTURE
//  Shared package/header mips_defs:
//    ALU_ADD/SUB/AND/OR/XOR/NOR/SLT/SLTU (3-bit)
//    FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
//  Sub-module: alu. Pure combinational: inputs a, b, ctrl; outputs y, overflow, zero.
//  Top holds the forward muxes, dest mux and the EX/MEM register block.
// TESTING
//  1. Reset: rst=0 mid-run -> all outputs 0 immediately, with no clk edge.
//  2. add: RD1E=5, SignImmE=7, ALUSrcE=1, ctrl 010 -> next cycle ALUOutM=12, ValidM=1.
//  3. Forwarding: sub with ForwardAE=10 (ALUOutM=12) and ForwardBE=01 (ResultW=2).
//     -> ALUOutM=10, WriteDataM=2.
//  4. Overflow: add 0x7FFFFFFF+1 -> ALUOutM=0x80000000, OverflowM=1.
//     Check also slt -1<1 -> 1, sltu 0xFFFFFFFF<1 -> 0.
//  5. stallM=1 for 3 cycles with changing E inputs -> all M outputs frozen.
//     After release, the next edge loads the current E values.
//  6. flushM=1 together with stallM=1 -> all M outputs 0, ValidM=0.
//     RegDstE=1 with RdE=9 then loads WriteRegM=9.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// ---------------------------------------------------------------------------
// mips_defs_pkg
// Shared encodings for the MIPS pipeline datapath.
//   ALU_*  : 3-bit ALU control codes produced by the decoder
//   FWD_*  : 2-bit operand-forwarding selects produced by the hazard unit
// ---------------------------------------------------------------------------
package mips_defs_pkg;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_XOR  = 3'b011;
   localparam logic [2:0] ALU_NOR  = 3'b100;
   localparam logic [2:0] ALU_SLTU = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   // 2'b11 is not assigned; consumers treat it like FWD_RF.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational ALU for the execute stage.
//   a, b      : operands (WIDTH)
//   ctrl      : operation select (ALU_* codes)
//   y         : result, wraps modulo 2^WIDTH
//   overflow  : signed overflow, meaningful for add/sub only (0 otherwise)
//   zero      : y == 0
// ---------------------------------------------------------------------------
module alu
   import mips_defs_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       ctrl,
   output logic [WIDTH-1:0] y,
   output logic             overflow,
   output logic             zero
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      y        = '0;
      overflow = 1'b0;
      case (ctrl)
         ALU_ADD: begin
            y = sum;
            // Like-signed operands producing an opposite-signed sum.
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            y = diff;
            // Unlike-signed operands where the result sign departs from a.
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_NOR:  y = ~(a | b);
         ALU_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
         default: begin
            y        = '0;
            overflow = 1'b0;
         end
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/execute_mem_reg.sv
// ---------------------------------------------------------------------------
// execute_mem_reg
// Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline.
//   clk, rst (async, active low)
//   stallM, flushM              : EX/MEM register control
//   *E inputs                   : ID/EX register contents
//   ForwardAE/BE, ResultW       : operand forwarding from hazard unit / WB
//   *M outputs                  : EX/MEM register contents
//
// Pipeline register control: on each rising edge flushM clears every M
// register (bubble, ValidM=0), otherwise stallM holds them, otherwise they
// load the E-stage values. flushM wins over stallM; a bubble inserted under
// stall keeps holding while stallM stays high.
//
// Forwarding from ALUOutM uses the registered value, so there is no
// combinational path from the ALU back into itself, and while stalled the
// forwarded operand stays constant.
// ---------------------------------------------------------------------------
module execute_mem_reg
   import mips_defs_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int REGBITS = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallM,
   input  logic               flushM,
   input  logic               RegWriteE,
   input  logic               MemtoRegE,
   input  logic               MemWriteE,
   input  logic               ALUSrcE,
   input  logic               RegDstE,
   input  logic [2:0]         ALUControlE,
   input  logic [WIDTH-1:0]   RD1E,
   input  logic [WIDTH-1:0]   RD2E,
   input  logic [WIDTH-1:0]   SignImmE,
   input  logic [REGBITS-1:0] RtE,
   input  logic [REGBITS-1:0] RdE,
   input  logic [1:0]         ForwardAE,
   input  logic [1:0]         ForwardBE,
   input  logic [WIDTH-1:0]   ResultW,
   output logic               RegWriteM,
   output logic               MemtoRegM,
   output logic               MemWriteM,
   output logic [WIDTH-1:0]   ALUOutM,
   output logic [WIDTH-1:0]   WriteDataM,
   output logic [REGBITS-1:0] WriteRegM,
   output logic               OverflowM,
   output logic               ValidM
);

   logic [WIDTH-1:0]   src_a;
   logic [WIDTH-1:0]   fwd_b;
   logic [WIDTH-1:0]   src_b;
   logic [WIDTH-1:0]   alu_out_e;
   logic               overflow_e;
   logic               alu_zero_unused;
   logic [REGBITS-1:0] write_reg_e;
   logic               valid_e;

   // Operand A forward mux.
   always_comb begin
      src_a = RD1E;
      case (ForwardAE)
         FWD_WB:  src_a = ResultW;
         FWD_MEM: src_a = ALUOutM;
         default: src_a = RD1E;
      endcase
   end

   // Operand B forward mux; its output is also the store data.
   always_comb begin
      fwd_b = RD2E;
      case (ForwardBE)
         FWD_WB:  fwd_b = ResultW;
         FWD_MEM: fwd_b = ALUOutM;
         default: fwd_b = RD2E;
      endcase
   end

   assign src_b = ALUSrcE ? SignImmE : fwd_b;

   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a        (src_a),
      .b        (src_b),
      .ctrl     (ALUControlE),
      .y        (alu_out_e),
      .overflow (overflow_e),
      .zero     (alu_zero_unused)
   );

   assign write_reg_e = RegDstE ? RdE : RtE;

   // An all-zero ID/EX bubble decodes as "and r0" with no writes: not valid.
   assign valid_e = RegWriteE | MemWriteE | (ALUControlE != ALU_AND) | (RtE != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteM  <= 1'b0;
         MemtoRegM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ALUOutM    <= '0;
         WriteDataM <= '0;
         WriteRegM  <= '0;
         OverflowM  <= 1'b0;
         ValidM     <= 1'b0;
      end else if (flushM) begin
         RegWriteM  <= 1'b0;
         MemtoRegM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ALUOutM    <= '0;
         WriteDataM <= '0;
         WriteRegM  <= '0;
         OverflowM  <= 1'b0;
         ValidM     <= 1'b0;
      end else if (!stallM) begin
         RegWriteM  <= RegWriteE;
         MemtoRegM  <= MemtoRegE;
         MemWriteM  <= MemWriteE;
         ALUOutM    <= alu_out_e;
         WriteDataM <= fwd_b;
         WriteRegM  <= write_reg_e;
         OverflowM  <= overflow_e;
         ValidM     <= valid_e;
      end
   end

endmodule
